core_cluster: RTL and testbench



---
 rtl/core_pkg.sv | 33 +++
 rtl/core.sv | 55 +++++
 rtl/out_serializer.sv | 91 +++++++++
 rtl/core_cluster.sv | 154 +++++++++++++++
 tb/tb_core_cluster.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for core_cluster: misc-command fields, mask command
// encodings, core opcode classes and the result serializer state type.
package core_pkg;

  // Misc command prefix on opcode[15:14]
  localparam logic [1:0] MISC_PREFIX = 2'b11;

  // Misc command field positions
  localparam int STORE_BIT = 7;
  localparam int MASK_HI   = 6;
  localparam int MASK_LO   = 5;
  localparam int OUT_BIT   = 4;
  localparam int IDX_HI    = 12;
  localparam int IDX_LO    = 9;

  // Mask command encodings on opcode[6:5]
  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_ONE  = 2'b01;
  localparam logic [1:0] MASK_ALL  = 2'b10;
  localparam logic [1:0] MASK_ADD  = 2'b11;

  // Core arithmetic opcode classes on opcode[15:14]
  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_ADDG = 2'b01;
  localparam logic [1:0] OP_MULI = 2'b10;

  // Result serializer states
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/core.sv
// Single compute core: one 2*BIT_WIDTH accumulator driven by the shared
// opcode stream.
//   LDI  (00): accu <= zero-extended opcode[13:0]
//   ADDG (01): accu <= accu + greg[opcode[12:9]]
//   MULI (10): accu <= accu * opcode[7:0]
//   misc (11): handled by the cluster, accumulator holds
module core
  import core_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              opcode,
  input  logic                     execute,
  input  logic [16*BIT_WIDTH-1:0]  greg_bus,
  output logic [2*BIT_WIDTH-1:0]   accu
);

  localparam int AW = 2 * BIT_WIDTH;

  logic [AW-1:0] imm_ldi;
  logic [AW-1:0] imm_mul;
  logic [AW-1:0] gval;
  logic [AW-1:0] accu_next;

  assign imm_ldi = AW'(opcode[13:0]);
  assign imm_mul = AW'(opcode[7:0]);
  assign gval    = AW'(greg_bus[opcode[IDX_HI:IDX_LO]*BIT_WIDTH +: BIT_WIDTH]);

  // Next accumulator value for the opcode presented this cycle
  always_comb begin
    accu_next = accu;
    if (execute) begin
      case (opcode[15:14])
        OP_LDI:  accu_next = imm_ldi;
        OP_ADDG: accu_next = accu + gval;
        OP_MULI: accu_next = accu * imm_mul;
        default: accu_next = accu;
      endcase
    end else begin
      accu_next = accu;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      accu <= '0;
    end else begin
      accu <= accu_next;
    end
  end

endmodule

// File: rtl/out_serializer.sv
// Result serializer: captures OUT_WIDTH bits on an accepted command and
// shifts them out LSB first, one per cycle. A command accepted in the
// last-bit cycle reloads directly, giving a gapless stream. Commands that
// arrive while busy are dropped and latch the sticky overrun flag.
module out_serializer
  import core_pkg::*;
#(
  parameter int OUT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OUT_WIDTH-1:0] data,
  output logic                 valid_bit,
  output logic                 output_bit,
  output logic                 out_ready,
  output logic                 overrun
);

  localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  ser_state_t           state;
  ser_state_t           state_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;
  logic [OUT_WIDTH-1:0] sreg;
  logic [OUT_WIDTH-1:0] sreg_next;
  logic                 accept;

  // Ready depends on state only, never on the incoming opcode
  assign out_ready  = (state == SER_IDLE) | ((state == SER_SHIFT) & (cnt == '0));
  assign accept     = start & out_ready;
  assign output_bit = sreg[0];

  // Next-state, counter and shift-register logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sreg_next  = sreg;
    case (state)
      SER_IDLE: begin
        if (accept) begin
          state_next = SER_SHIFT;
          cnt_next   = CW'(OUT_WIDTH - 1);
          sreg_next  = data;
        end else begin
          state_next = SER_IDLE;
          cnt_next   = '0;
          sreg_next  = '0;
        end
      end
      SER_SHIFT: begin
        if (cnt != '0) begin
          cnt_next  = cnt - CW'(1);
          sreg_next = sreg >> 1;
        end else if (accept) begin
          state_next = SER_SHIFT;
          cnt_next   = CW'(OUT_WIDTH - 1);
          sreg_next  = data;
        end else begin
          state_next = SER_IDLE;
          cnt_next   = '0;
          sreg_next  = '0;
        end
      end
      default: begin
        state_next = SER_IDLE;
        cnt_next   = '0;
        sreg_next  = '0;
      end
    endcase
  end

  // State, counter, data and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SER_IDLE;
      cnt       <= '0;
      sreg      <= '0;
      valid_bit <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      sreg      <= sreg_next;
      valid_bit <= (state_next == SER_SHIFT);
      overrun   <= overrun | (start & ~out_ready);
    end
  end

endmodule

// File: rtl/core_cluster.sv
// core_cluster: NR_CORES cores on one opcode stream, the global register
// file with lowest-enabled-core store arbitration, the core-enable mask and
// the result serializer.
// Optional feature macro: CORE_CLUSTER_MASK_EN -- mask command 2'b11 ORs
// core 'sel' into the enable mask; without it 2'b11 leaves the mask alone.
module core_cluster
  import core_pkg::*;
#(
  parameter int NR_CORES    = 4,
  parameter int BIT_WIDTH   = 8,
  parameter int GLOBAL_REGS = 12,
  parameter int OUT_WIDTH   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] opcode,
  input  logic        execute,
  output logic        valid_bit,
  output logic        output_bit,
  output logic        out_ready,
  output logic        overrun
);

  localparam int CORE_ADDR_WIDTH = (NR_CORES > 1) ? $clog2(NR_CORES) : 1;
  localparam int AW              = 2 * BIT_WIDTH;

  logic [NR_CORES-1:0]        en_mask;
  logic [NR_CORES-1:0]        mask_next;
  logic [BIT_WIDTH-1:0]       greg [GLOBAL_REGS];
  logic [16*BIT_WIDTH-1:0]    greg_bus;
  logic [AW-1:0]              accu [NR_CORES];
  logic [AW-1:0]              sel_accu;
  logic [AW-1:0]              store_accu;
  logic [CORE_ADDR_WIDTH-1:0] sel;
  logic [3:0]                 idx;
  logic [1:0]                 mask_cmd;
  logic                       is_misc;
  logic                       do_store;
  logic                       do_out;
  logic                       store_ok;
  logic                       unused_accu_hi;

  assign is_misc  = execute & (opcode[15:14] == MISC_PREFIX);
  assign sel      = opcode[CORE_ADDR_WIDTH+8:9];
  assign idx      = opcode[IDX_HI:IDX_LO];
  assign mask_cmd = opcode[MASK_HI:MASK_LO];
  assign do_store = is_misc & opcode[STORE_BIT];
  assign do_out   = is_misc & opcode[OUT_BIT];
  // Stores need a non-empty mask and an implemented register index
  assign store_ok = do_store & (|en_mask) & (int'(idx) < GLOBAL_REGS);

  // Upper accumulator bits are only consumed for wide serializer settings
  assign unused_accu_hi = ^{sel_accu, store_accu};

  // Store source is the lowest enabled core; output source is core 'sel'
  always_comb begin
    store_accu = '0;
    sel_accu   = '0;
    for (int y = NR_CORES - 1; y >= 0; y--) begin
      if (en_mask[y]) begin
        store_accu = accu[y];
      end else begin
        store_accu = store_accu;
      end
    end
    for (int y = 0; y < NR_CORES; y++) begin
      if (sel == CORE_ADDR_WIDTH'(y)) begin
        sel_accu = accu[y];
      end else begin
        sel_accu = sel_accu;
      end
    end
  end

  // Mask update from the misc mask command
  always_comb begin
    mask_next = en_mask;
    if (is_misc) begin
      case (mask_cmd)
        MASK_NONE: mask_next = en_mask;
        MASK_ONE: begin
          for (int y = 0; y < NR_CORES; y++) begin
            mask_next[y] = (sel == CORE_ADDR_WIDTH'(y));
          end
        end
        MASK_ALL: mask_next = '1;
`ifdef CORE_CLUSTER_MASK_EN
        MASK_ADD: begin
          for (int y = 0; y < NR_CORES; y++) begin
            mask_next[y] = en_mask[y] | (sel == CORE_ADDR_WIDTH'(y));
          end
        end
`else
        MASK_ADD: mask_next = en_mask;
`endif
        default: mask_next = en_mask;
      endcase
    end else begin
      mask_next = en_mask;
    end
  end

  // Enable mask and global register file; the store sees the old mask
  always_ff @(posedge clk) begin
    if (rst) begin
      en_mask <= '1;
      for (int g = 0; g < GLOBAL_REGS; g++) begin
        greg[g] <= '0;
      end
    end else begin
      en_mask <= mask_next;
      for (int g = 0; g < GLOBAL_REGS; g++) begin
        if (store_ok && (idx == 4'(g))) begin
          greg[g] <= store_accu[BIT_WIDTH-1:0];
        end
      end
    end
  end

  // Flatten the register file for the cores; unimplemented entries read 0
  always_comb begin
    greg_bus = '0;
    for (int g = 0; g < GLOBAL_REGS; g++) begin
      greg_bus[g*BIT_WIDTH +: BIT_WIDTH] = greg[g];
    end
  end

  for (genvar y = 0; y < NR_CORES; y++) begin : g_core
    core #(
      .BIT_WIDTH(BIT_WIDTH)
    ) u_core (
      .clk      (clk),
      .rst      (rst),
      .opcode   (opcode),
      .execute  (execute & en_mask[y]),
      .greg_bus (greg_bus),
      .accu     (accu[y])
    );
  end

  out_serializer #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_out_serializer (
    .clk        (clk),
    .rst        (rst),
    .start      (do_out),
    .data       (sel_accu[OUT_WIDTH-1:0]),
    .valid_bit  (valid_bit),
    .output_bit (output_bit),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_core_cluster.sv
// Directed self-checking bench for core_cluster (NR_CORES=4, BIT_WIDTH=8,
// GLOBAL_REGS=12, OUT_WIDTH=4). Expected mask result depends on
// CORE_CLUSTER_MASK_EN.
module tb_core_cluster;

  logic        clk;
  logic        rst;
  logic [15:0] opcode;
  logic        execute;
  logic        valid_bit;
  logic        output_bit;
  logic        out_ready;
  logic        overrun;

  int n_checks;
  int n_pass;

  core_cluster #(
    .NR_CORES    (4),
    .BIT_WIDTH   (8),
    .GLOBAL_REGS (12),
    .OUT_WIDTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .execute    (execute),
    .valid_bit  (valid_bit),
    .output_bit (output_bit),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misc_op(input logic [3:0] idx, input logic store,
                                          input logic [1:0] mcmd, input logic out);
    return {2'b11, 1'b0, idx, 1'b0, store, mcmd, out, 4'b0000};
  endfunction

  function automatic logic [15:0] ldi_op(input logic [13:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [15:0] addg_op(input logic [3:0] idx);
    return {2'b01, 1'b0, idx, 9'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [15:0] op);
    opcode  = op;
    execute = 1'b1;
    @(posedge clk);
    #1;
    execute = 1'b0;
    opcode  = 16'h0000;
  endtask

  logic [127:0] exp_bus;
  logic [7:0]   exp_bits;
  logic [3:0]   nib_b;
  logic [3:0]   exp_mask;
  logic [15:0]  exp_acc3;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    opcode   = 16'h0000;
    execute  = 1'b0;
    nib_b    = 4'hB;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_valid", valid_bit, 1'b0);
    check("rst_bit", output_bit, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ready", out_ready, 1'b1);
    check("rst_greg", dut.greg_bus, 128'd0);
    check("rst_mask", dut.en_mask, 4'hF);

    // Per-core loads: core0=0x11, core1=0x22, core2=0x0B
    step(misc_op(4'd0, 1'b0, 2'b01, 1'b0));
    step(ldi_op(14'h0011));
    step(misc_op(4'd1, 1'b0, 2'b01, 1'b0));
    step(ldi_op(14'h0022));
    step(misc_op(4'd2, 1'b0, 2'b01, 1'b0));
    step(ldi_op(14'h000B));
    step(misc_op(4'd0, 1'b0, 2'b10, 1'b0));
    check("mask_all", dut.en_mask, 4'hF);
    check("acc1_load", dut.g_core[1].u_core.accu, 16'h0022);

    // Global stores: lowest enabled core wins, out-of-range indices ignored
    step(misc_op(4'd3, 1'b1, 2'b00, 1'b0));
    check("store3", dut.greg_bus[3*8 +: 8], 8'h11);
    step(misc_op(4'd14, 1'b1, 2'b00, 1'b0));
    step(misc_op(4'd12, 1'b1, 2'b00, 1'b0));
    exp_bus = 128'h11 << 24;
    check("store_oob", dut.greg_bus, exp_bus);
    // Store plus mask change in one opcode: store uses the old (all-ones) mask
    step(misc_op(4'd5, 1'b1, 2'b01, 1'b0));
    check("store_oldmask", dut.greg_bus[5*8 +: 8], 8'h11);
    check("mask_one1", dut.en_mask, 4'b0010);
    step(misc_op(4'd6, 1'b1, 2'b00, 1'b0));
    check("store_core1", dut.greg_bus[6*8 +: 8], 8'h22);
    step(misc_op(4'd0, 1'b0, 2'b10, 1'b0));

    // Single 4-bit stream of core 2 (0xB -> 1,1,0,1)
    step(misc_op(4'd2, 1'b0, 2'b00, 1'b1));
    check("busy_ready", out_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("s1_valid", valid_bit, 1'b1);
      check("s1_bit", output_bit, nib_b[i]);
      if (i == 3) begin
        check("last_ready", out_ready, 1'b1);
      end
      tick();
    end
    check("s1_end", valid_bit, 1'b0);

    // Back-to-back: core 2 then core 1 (0x2) issued in the last-bit cycle
    exp_bits = 8'h2B;
    step(misc_op(4'd2, 1'b0, 2'b00, 1'b1));
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", valid_bit, 1'b1);
      check("b2b_bit", output_bit, exp_bits[i]);
      if (i == 3) begin
        step(misc_op(4'd1, 1'b0, 2'b00, 1'b1));
      end else begin
        tick();
      end
    end
    check("b2b_end", valid_bit, 1'b0);
    check("b2b_overrun", overrun, 1'b0);

    // Command while busy is dropped and sets overrun
    step(misc_op(4'd2, 1'b0, 2'b00, 1'b1));
    step(misc_op(4'd0, 1'b0, 2'b00, 1'b1));
    check("ovr_set", overrun, 1'b1);
    check("ovr_bit1", output_bit, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check("ovr_drain", valid_bit, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // Global register visible to cores: all add greg[5]=0x11
    step(addg_op(4'd5));
    check("addg0", dut.g_core[0].u_core.accu, 16'h0022);
    check("addg2", dut.g_core[2].u_core.accu, 16'h001C);

    // Mask add: one-hot core 1, then 2'b11 with sel=3
`ifdef CORE_CLUSTER_MASK_EN
    exp_mask = 4'b1010;
    exp_acc3 = 16'h005A;
`else
    exp_mask = 4'b0010;
    exp_acc3 = 16'h0011;
`endif
    step(misc_op(4'd1, 1'b0, 2'b01, 1'b0));
    step(misc_op(4'd3, 1'b0, 2'b11, 1'b0));
    check("mask_add", dut.en_mask, exp_mask);
    step(ldi_op(14'h005A));
    check("madd_acc1", dut.g_core[1].u_core.accu, 16'h005A);
    check("madd_acc3", dut.g_core[3].u_core.accu, exp_acc3);
    check("madd_acc0", dut.g_core[0].u_core.accu, 16'h0022);

    // Reset during the second bit of a stream
    step(misc_op(4'd0, 1'b0, 2'b10, 1'b0));
    step(misc_op(4'd1, 1'b0, 2'b00, 1'b1));
    check("mid_bit0", valid_bit, 1'b1);
    tick();
    check("mid_bit1", valid_bit, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", valid_bit, 1'b0);
    check("mid_rst_bit", output_bit, 1'b0);
    rst = 1'b0;
    tick();
    check("mid_after_valid", valid_bit, 1'b0);
    tick();
    check("mid_after_valid2", valid_bit, 1'b0);
    check("mid_mask", dut.en_mask, 4'hF);
    check("mid_overrun", overrun, 1'b0);
    check("mid_ready", out_ready, 1'b1);
    check("mid_greg", dut.greg_bus, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
